sat_result_fifo: RTL and testbench
==================================

# sat_result_fifo

Result-capture stage directly downstream of the 4-bit saturating add/subtract unit. Each cycle, it can accept one result `{s, overflow, mode}` through a valid/ready handshake. Results are buffered in a small FIFO and presented to the consumer through a second valid/ready handshake. The block also keeps a sticky overflow flag and a saturating count of overflow events for status readout.

## Interface
- `DEPTH`, 4: number of FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of the overflow event counter.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  upstream result valid.
- `in_ready`  out  1  FIFO can accept; equals (occupancy < DEPTH).
- `in_s`  in  4  saturated result from the adder.
- `in_ovf`  in  1  overflow flag from the adder.
- `in_mode`  in  1  operation that produced the result (1 = add, 0 = subtract).
- `out_valid`  out  1  head entry valid; equals (occupancy > 0).
- `out_ready`  in  1  consumer accepts head entry.
- `out_s`  out  4  head entry result; 0 when empty.
- `out_ovf`  out  1  head entry overflow; 0 when empty.
- `out_mode`  out  1  head entry mode; 0 when empty.
- `occupancy`  out  $clog2(DEPTH)+1  entries held.
- `ovf_sticky`  out  1  set by any accepted entry with `in_ovf` = 1.
- `ovf_cnt`  out  CNT_W  accepted overflow entries, saturating.
- `clr_stats`  in  1  synchronous clear of `ovf_sticky` and `ovf_cnt`.

## Operation
- Push occurs when `in_valid && in_ready`. `{in_s, in_ovf, in_mode}` is written at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- Pop occurs when `out_valid && out_ready`. `rd_ptr` increments modulo DEPTH.
- Occupancy update:
  - push only: +1
  - pop only: −1
  - both or neither: unchanged
- Full (occupancy = DEPTH):
  - `in_ready` = 0, even if a pop occurs in the same cycle. There is no full-bypass.
  - A push attempted while full is ignored. Upstream must hold its data.
- Empty (occupancy = 0):
  - `out_valid` = 0 and the `out_*` data outputs read 0.
  - A pop attempted while empty is ignored.
  - There is no empty-bypass: an entry pushed into an empty FIFO is not visible in the same cycle.
- Push and pop together while neither full nor empty: both happen, and occupancy is unchanged.
- Stored data never changes after it is written. The `out_*` outputs are a mux of storage at `rd_ptr`.
- Overflow statistics, evaluated on each push with `in_ovf` = 1:
  - `ovf_sticky` is set to 1.
  - `ovf_cnt` increments, holding at 2^CNT_W−1.
  - Overflow entries are counted only on a push, not on a pop.
- `clr_stats` in a cycle with no overflow push: `ovf_sticky` becomes 0 and `ovf_cnt` becomes 0.
- `clr_stats` in the same cycle as an overflow push: `ovf_sticky` becomes 1 and `ovf_cnt` becomes 1. The new event is not lost.
- `clr_stats` does not affect the FIFO contents or pointers.
- The block performs no arithmetic on the data and passes `in_s` unchanged. Saturation is the adder's responsibility.
- Internal state: write pointer, read pointer, occupancy, statistics. There is no separate FSM. The empty/partial/full state is derived from occupancy.

## Timing
- Reset (`rst_n` low, asynchronous) sets all of the following immediately, with no clock edge needed:
  - pointers = 0
  - occupancy = 0
  - `ovf_sticky` = 0
  - `ovf_cnt` = 0
  - `out_valid` = 0
  - `out_s`/`out_ovf`/`out_mode` = 0
  - `in_ready` = 1
- Reset asserted mid-operation discards all entries. The first push after deassertion goes to entry 0.
- Latency: an entry pushed at rising edge N drives `out_valid` = 1 with its data from after edge N. That is one cycle, the minimum.
- Throughput: one push and one pop per cycle in steady state.
- `in_ready` and `out_valid` depend only on registered occupancy. There is no combinational path from `in_valid` to `in_ready` or from `out_ready` to `out_valid`.
- There is no combinational path from `in_*` to `out_*`.
- Pointer wrap: after DEPTH pushes, `wr_ptr` returns to 0. Order is preserved across the wrap.

## Test plan
- **Reset values:** reset, then idle 3 cycles. Required: `in_ready` = 1, `out_valid` = 0, `occupancy` = 0, `out_s` = 0, `ovf_cnt` = 0.
- **Fill and overflow attempt:** push s = 1, 2, 3, 4 (`ovf` = 0) with `out_ready` = 0. Then attempt to push s = 5. Required: `occupancy` = 4, `in_ready` = 0, and the s = 5 push is dropped. Then pop 4 entries. Required: `out_s` reads 1, 2, 3, 4 in order, then `out_valid` = 0.
- **Wrap-around:** with `in_valid` and `out_ready` held high, stream 10 results s = 0..9. Required: outputs appear 0..9, each one cycle after its push, and `occupancy` stays at 1.
- **Statistics and saturation:** with `CNT_W` = 2, push `ovf` = 1 entries with s = 7 (positive saturation) five times. Required: `ovf_cnt` = 3 (held), `ovf_sticky` = 1. Then assert `clr_stats` alone. Required: `ovf_cnt` = 0, `ovf_sticky` = 0.
- **Clear collision:** assert `clr_stats` in the same cycle as pushing s = 8 with `ovf` = 1 (negative saturation). Required: `ovf_cnt` = 1, `ovf_sticky` = 1.
- **Reset mid-operation:** hold 3 entries, then pulse `rst_n` low between clock edges. Required: `out_valid` = 0 immediately. After release, push s = 0xA. Required: `out_s` = 0xA, `occupancy` = 1.

Source files
------------

// File: rtl/sat_result_fifo.sv
// sat_result_fifo: buffers adder results behind valid/ready handshakes and tracks overflow statistics
module sat_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_s,
  input  logic                       in_ovf,
  input  logic                       in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_s,
  output logic                       out_ovf,
  output logic                       out_mode,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       ovf_sticky,
  output logic [CNT_W-1:0]           ovf_cnt,
  input  logic                       clr_stats
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] full_lvl = (AW+1)'(DEPTH);
  logic [5:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop, ovf_push;
  assign in_ready = occupancy != full_lvl;
  assign out_valid = occupancy != '0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign ovf_push = push && in_ovf;
  assign {out_s, out_ovf, out_mode} = out_valid ? mem[rd_ptr] : 6'd0;
  // storage is write-only on push; empty-gating keeps stale contents off the outputs
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_s, in_ovf, in_mode};
  // pointers, occupancy and overflow statistics
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occupancy <= '0;
      ovf_sticky <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      occupancy <= (push && !pop) ? occupancy + 1'b1 : (pop && !push) ? occupancy - 1'b1 : occupancy;
      ovf_sticky <= ovf_push || (ovf_sticky && !clr_stats);
      ovf_cnt <= clr_stats ? CNT_W'(ovf_push) : (ovf_push && ovf_cnt != '1) ? ovf_cnt + 1'b1 : ovf_cnt;
    end
endmodule

// File: tb/tb_sat_result_fifo.sv
// tb_sat_result_fifo: directed checks of handshakes, ordering, wrap, statistics and reset
module tb_sat_result_fifo;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, in_ovf = 0, in_mode = 0;
  logic [3:0] in_s = 0, out_s;
  logic out_valid, out_ready = 0, out_ovf, out_mode;
  logic [2:0] occupancy;
  logic ovf_sticky, clr_stats = 0;
  logic [1:0] ovf_cnt;
  int checks = 0, errors = 0;

  sat_result_fifo #(.DEPTH(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_ovf(in_ovf), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_s(out_s), .out_ovf(out_ovf), .out_mode(out_mode),
    .occupancy(occupancy), .ovf_sticky(ovf_sticky), .ovf_cnt(ovf_cnt), .clr_stats(clr_stats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #12 rst_n = 1;
    repeat (3) step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_s", out_s, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    chk("rst_sticky", ovf_sticky, 0);

    in_valid = 1;
    for (int s = 1; s <= 4; s++) begin
      in_s = 4'(s);
      in_mode = s[0];
      step();
      chk("fill_occ", occupancy, s);
    end
    chk("full_in_ready", in_ready, 0);
    chk("fill_head_visible", out_valid, 1);
    in_s = 4'd5;
    in_mode = 1;
    step();
    chk("full_drop_occ", occupancy, 4);
    chk("full_drop_head", out_s, 1);
    in_valid = 0;
    out_ready = 1;
    for (int s = 1; s <= 4; s++) begin
      chk("pop_valid", out_valid, 1);
      chk("pop_s", out_s, s);
      chk("pop_mode", out_mode, s % 2);
      chk("pop_ovf", out_ovf, 0);
      step();
    end
    chk("drained_valid", out_valid, 0);
    chk("drained_s", out_s, 0);
    chk("drained_ready", in_ready, 1);

    in_valid = 1;
    in_mode = 0;
    for (int s = 0; s < 10; s++) begin
      in_s = 4'(s);
      step();
      chk("stream_s", out_s, s);
      chk("stream_occ", occupancy, 1);
    end
    in_valid = 0;
    step();
    chk("stream_end_occ", occupancy, 0);

    in_valid = 1;
    in_ovf = 1;
    in_s = 4'd7;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("sat_cnt", ovf_cnt, k > 3 ? 3 : k);
    end
    chk("sat_sticky", ovf_sticky, 1);
    chk("sat_out_ovf", out_ovf, 1);
    chk("sat_out_s", out_s, 7);
    in_valid = 0;
    in_ovf = 0;
    step();
    chk("sat_drain_cnt", ovf_cnt, 3);
    clr_stats = 1;
    step();
    clr_stats = 0;
    chk("clr_cnt", ovf_cnt, 0);
    chk("clr_sticky", ovf_sticky, 0);

    in_valid = 1;
    in_ovf = 1;
    in_s = 4'd8;
    clr_stats = 1;
    step();
    in_valid = 0;
    in_ovf = 0;
    clr_stats = 0;
    chk("coll_cnt", ovf_cnt, 1);
    chk("coll_sticky", ovf_sticky, 1);
    chk("coll_out_s", out_s, 8);
    step();
    chk("coll_drained", occupancy, 0);

    out_ready = 0;
    in_valid = 1;
    for (int s = 1; s <= 3; s++) begin
      in_s = 4'(s);
      step();
    end
    in_valid = 0;
    chk("mid_occ", occupancy, 3);
    #2 rst_n = 0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_occ", occupancy, 0);
    chk("async_ready", in_ready, 1);
    chk("async_cnt", ovf_cnt, 0);
    chk("async_sticky", ovf_sticky, 0);
    #1 rst_n = 1;
    step();
    in_valid = 1;
    in_s = 4'hA;
    step();
    in_valid = 0;
    chk("post_rst_s", out_s, 4'hA);
    chk("post_rst_occ", occupancy, 1);
    out_ready = 1;
    step();
    chk("post_rst_pop", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
